vproc_elem_res_pack: RTL

//   Consumer of the ELEM unit result stream: receives one element result per handshake
//   (32-bit value, result-valid flag, per-element write mask) and packs results of

---
 rtl/vproc_elem_res_pack.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vproc_elem_res_pack.sv
// Element result packer: collects per-element results of width EEW from the
// ELEM unit and packs them densely into VREG_W-bit vector register write words.
// Elements without a result (vcompress holes) take no slot. One byte-enabled
// write is issued per completed word, and for a partially filled word at the
// end of an instruction.
//
// Handshakes: a transfer happens on a port in every cycle where valid and
// ready are both high at the rising clock edge. The producer holds valid and
// its payload stable until that edge. in_ready_o does not depend on
// in_valid_i. vreg_wr_* stays stable while vreg_wr_valid_o is high and
// vreg_wr_ready_i is low.
module vproc_elem_res_pack #(
  parameter int unsigned VREG_W         = 128,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                sync_rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_first_i,
  input  logic                in_last_i,
  input  logic [1:0]          in_eew_i,
  input  logic [4:0]          in_vd_i,
  input  logic                in_res_valid_i,
  input  logic [31:0]         in_res_i,
  input  logic                in_mask_i,
  output logic                vreg_wr_valid_o,
  input  logic                vreg_wr_ready_i,
  output logic [4:0]          vreg_wr_addr_o,
  output logic [VREG_W-1:0]   vreg_wr_data_o,
  output logic [VREG_W/8-1:0] vreg_wr_be_o,
  output logic                busy_o
);

  localparam int unsigned NB = VREG_W / 8;
  localparam int unsigned PW = $clog2(NB);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t            state_q;
  logic [VREG_W-1:0] acc_data_q;
  logic [NB-1:0]     acc_be_q;
  logic [PW-1:0]     ptr_q;
  logic [4:0]        addr_q;
  logic [1:0]        eew_q;

  logic [VREG_W-1:0] out_data_q;
  logic [NB-1:0]     out_be_q;
  logic [4:0]        out_addr_q;
  logic              out_valid_q;

  logic              accept;
  logic [1:0]        eew_eff;
  logic [PW-1:0]     base_ptr;
  logic [NB-1:0]     base_be;
  logic [VREG_W-1:0] base_data;
  logic [4:0]        base_addr;
  logic              slot;
  logic [PW:0]       nbytes;
  logic [PW:0]       sum;
  logic [PW-1:0]     ptr_after;
  logic              wrap;
  logic              complete;
  logic [VREG_W-1:0] pack_data;
  logic [NB-1:0]     pack_be;

  // Input can be taken whenever the output register is free or draining now.
  assign in_ready_o = ~out_valid_q | vreg_wr_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  assign vreg_wr_valid_o = out_valid_q;
  assign vreg_wr_addr_o  = out_addr_q;
  assign vreg_wr_data_o  = out_data_q;
  assign vreg_wr_be_o    = out_be_q;
  assign busy_o          = (state_q == ST_FILL) | out_valid_q;

  // Merge the incoming element into the accumulator and detect word completion.
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    // A first element restarts the word at byte 0 with its own eew and vd.
    eew_eff   = in_first_i ? in_eew_i : eew_q;
    base_ptr  = in_first_i ? '0 : ptr_q;
    base_be   = in_first_i ? '0 : acc_be_q;
    base_addr = in_first_i ? in_vd_i : addr_q;
    base_data = acc_data_q;
    if (DONT_CARE_ZERO && in_first_i) begin
      base_data = '0;
    end
    // eew=3 is illegal: such an element never takes a slot.
    slot = in_res_valid_i & (eew_eff != 2'd3);
    case (eew_eff)
      2'd0:    nbytes = (PW+1)'(1);
      2'd1:    nbytes = (PW+1)'(2);
      default: nbytes = (PW+1)'(4);
    endcase
    // Pointer stays aligned to the element size, so the add never overshoots NB.
    sum       = {1'b0, base_ptr} + (slot ? nbytes : '0);
    wrap      = slot & sum[PW];
    ptr_after = sum[PW-1:0];
    complete  = wrap | (in_last_i & (ptr_after != '0));
    pack_data = base_data;
    pack_be   = base_be;
    if (slot) begin
      for (int i = 0; i < int'(NB); i++) begin
        off = PW'(i) - base_ptr;
        if ({1'b0, off} < nbytes) begin
          pack_data[8*i +: 8] = in_res_i[8*off[1:0] +: 8];
          pack_be[i]          = in_mask_i;
        end
      end
    end
  end

  // Instruction FSM, accumulator and output register.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q     <= ST_IDLE;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      eew_q       <= '0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (!sync_rst_ni) begin
      state_q     <= ST_IDLE;
      acc_data_q  <= '0;
      acc_be_q    <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      eew_q       <= '0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && vreg_wr_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        eew_q <= eew_eff;
        // An element ending the instruction leaves the next one starting at byte 0.
        ptr_q <= in_last_i ? '0 : ptr_after;
        if (complete) begin
          // Reloads the output register in the same cycle it drains: no bubble.
          out_data_q  <= pack_data;
          out_be_q    <= pack_be;
          out_addr_q  <= base_addr;
          out_valid_q <= 1'b1;
          acc_be_q    <= '0;
          acc_data_q  <= DONT_CARE_ZERO ? '0 : pack_data;
          addr_q      <= base_addr + 5'd1;
        end else begin
          acc_be_q    <= in_last_i ? '0 : pack_be;
          acc_data_q  <= pack_data;
          addr_q      <= base_addr;
        end
        if (in_last_i) begin
          state_q <= ST_IDLE;
        end else if (in_first_i) begin
          state_q <= ST_FILL;
        end
      end
    end
  end

endmodule
